// File: rtl/sc_fetch_unit_if.sv
// Instruction-memory fetch bus: request/address from the fetch unit,
// acknowledge/read data from the memory.
interface sc_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/sc_fetch_unit.sv
// Instruction-fetch stage of the single-cycle CPU.
// Owns the PC and fetches each instruction over a req/ack handshake.
// It holds the fetched word for decode/execute until the downstream logic commits it.
// It forms the next PC from the decoder's pcsource and the jr register value.
// An imem timeout or a misaligned jr target parks the unit in a sticky error state.
// Only reset leaves that state.
module sc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic            clock,
   input  logic            reset,
   sc_fetch_unit_if.master imem,
   output logic [31:0]     inst,
   output logic            inst_valid,
   input  logic            commit,
   input  logic [1:0]      pcsource,
   input  logic [31:0]     ra,
   output logic [31:0]     pc,
   output logic [31:0]     pc4,
   output logic            fetch_err
);

   localparam int unsigned CNT_W      = $clog2(TIMEOUT + 1);
   // Force word alignment so pc[1:0] is 00 even for an odd reset vector.
   localparam logic [31:0] RESET_PC_A = {RESET_PC[31:2], 2'b00};

   typedef enum logic [1:0] {
      ST_REQ  = 2'b00,
      ST_HOLD = 2'b01,
      ST_ERR  = 2'b10
   } state_t;

   state_t             state_r;
   state_t             state_nx_s;

   logic [31:0]        pc_r;
   logic [31:0]        pc4_r;
   logic [31:0]        inst_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               req_r;
   logic               valid_r;
   logic               err_r;

   logic               ack_s;
   logic               timeout_s;
   logic               jr_bad_s;
   logic [CNT_W-1:0]   cnt_inc_s;
   logic [31:0]        branch_off_s;
   logic [31:0]        next_pc_s;

   logic               req_nx_s;
   logic               valid_nx_s;
   logic               err_nx_s;
   logic               load_inst_s;
   logic               load_pc_s;
   logic [CNT_W-1:0]   cnt_nx_s;

   // An ack counts only while a request is actually on the bus. This excludes the idle cycle right after reset.
   assign ack_s        = imem.imem_ack & req_r;
   assign cnt_inc_s    = cnt_r + CNT_W'(1);
   assign timeout_s    = req_r & ~imem.imem_ack & (cnt_inc_s == CNT_W'(TIMEOUT));
   assign jr_bad_s     = (pcsource == 2'b10) && (ra[1:0] != 2'b00);
   assign branch_off_s = {{14{inst_r[15]}}, inst_r[15:0], 2'b00};

   // Next-PC selection from the held instruction; all sums wrap modulo 2^32.
   always_comb begin
      next_pc_s = pc4_r;
      case (pcsource)
         2'b00:   next_pc_s = pc4_r;
         2'b01:   next_pc_s = pc4_r + branch_off_s;
         2'b10:   next_pc_s = ra;
         2'b11:   next_pc_s = {pc4_r[31:28], inst_r[25:0], 2'b00};
         default: next_pc_s = pc4_r;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= ST_REQ;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_REQ: begin
            if (ack_s) begin
               state_nx_s = ST_HOLD;
            end else if (timeout_s) begin
               state_nx_s = ST_ERR;
            end else begin
               state_nx_s = ST_REQ;
            end
         end
         ST_HOLD: begin
            if (commit) begin
               if (jr_bad_s) begin
                  state_nx_s = ST_ERR;
               end else begin
                  state_nx_s = ST_REQ;
               end
            end else begin
               state_nx_s = ST_HOLD;
            end
         end
         ST_ERR:  state_nx_s = ST_ERR;
         default: state_nx_s = ST_ERR;
      endcase
   end

   // FSM output logic: next values of the registered outputs and datapath load enables.
   always_comb begin
      req_nx_s    = 1'b0;
      valid_nx_s  = 1'b0;
      err_nx_s    = 1'b0;
      load_inst_s = 1'b0;
      load_pc_s   = 1'b0;
      cnt_nx_s    = '0;
      case (state_nx_s)
         ST_REQ:  req_nx_s   = 1'b1;
         ST_HOLD: valid_nx_s = 1'b1;
         ST_ERR:  err_nx_s   = 1'b1;
         default: err_nx_s   = 1'b1;
      endcase
      if ((state_r == ST_REQ) && ack_s) begin
         load_inst_s = 1'b1;
      end else begin
         load_inst_s = 1'b0;
      end
      if ((state_r == ST_HOLD) && commit && !jr_bad_s) begin
         load_pc_s = 1'b1;
      end else begin
         load_pc_s = 1'b0;
      end
      if ((state_r == ST_REQ) && req_r && !imem.imem_ack) begin
         cnt_nx_s = cnt_inc_s;
      end else begin
         cnt_nx_s = '0;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_r    <= RESET_PC_A;
         pc4_r   <= RESET_PC_A + 32'd4;
         inst_r  <= 32'h0000_0000;
         cnt_r   <= '0;
         req_r   <= 1'b0;
         valid_r <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         req_r   <= req_nx_s;
         valid_r <= valid_nx_s;
         err_r   <= err_nx_s;
         cnt_r   <= cnt_nx_s;
         if (load_inst_s) begin
            inst_r <= imem.imem_rdata;
         end
         if (load_pc_s) begin
            pc_r  <= next_pc_s;
            pc4_r <= next_pc_s + 32'd4;
         end
      end
   end

   assign imem.imem_req  = req_r;
   assign imem.imem_addr = pc_r;
   assign inst           = inst_r;
   assign inst_valid     = valid_r;
   assign pc             = pc_r;
   assign pc4            = pc4_r;
   assign fetch_err      = err_r;

endmodule

// File: tb/tb_sc_fetch_unit.sv
// Directed bench for sc_fetch_unit.
// A table of per-cycle vectors covers sequential fetch, branch, jr, j and wrap, plus the misaligned-jr fault.
// Hand-written sequences cover the imem timeout and reset during a pending request.
module tb_sc_fetch_unit;

   logic        clock;
   logic        reset;
   logic [31:0] inst;
   logic        inst_valid;
   logic        commit;
   logic [1:0]  pcsource;
   logic [31:0] ra;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic        fetch_err;

   sc_fetch_unit_if bus ();

   sc_fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .TIMEOUT  (16)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .imem       (bus),
      .inst       (inst),
      .inst_valid (inst_valid),
      .commit     (commit),
      .pcsource   (pcsource),
      .ra         (ra),
      .pc         (pc),
      .pc4        (pc4),
      .fetch_err  (fetch_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        ack;
      logic [31:0] rdata;
      logic        cmt;
      logic [1:0]  psrc;
      logic [31:0] rav;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_inst;
      logic [31:0] e_pc4;
      logic        e_err;
   } vec_t;

   vec_t vq[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input logic a, input logic [31:0] rd, input logic c,
                               input logic [1:0] ps, input logic [31:0] r,
                               input logic er, input logic [31:0] ea, input logic ev,
                               input logic [31:0] ei, input logic [31:0] ep4,
                               input logic ee);
      vec_t v;
      v.ack = a; v.rdata = rd; v.cmt = c; v.psrc = ps; v.rav = r;
      v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_inst = ei;
      v.e_pc4 = ep4; v.e_err = ee;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic a, input logic [31:0] rd, input logic c,
                        input logic [1:0] ps, input logic [31:0] r);
      bus.imem_ack   = a;
      bus.imem_rdata = rd;
      commit         = c;
      pcsource       = ps;
      ra             = r;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Hold reset for two edges, check the reset state, release just after an edge.
   task automatic do_reset(input string tag);
      drive(1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
      reset = 1'b1;
      step();
      step();
      chk({tag, " rst req"},   bus.imem_req, 32'd0);
      chk({tag, " rst addr"},  bus.imem_addr, 32'h0000_0000);
      chk({tag, " rst pc4"},   pc4, 32'h0000_0004);
      chk({tag, " rst valid"}, inst_valid, 32'd0);
      chk({tag, " rst inst"},  inst, 32'h0000_0000);
      chk({tag, " rst err"},   fetch_err, 32'd0);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 2'b00, 32'h0);

      // ack, rdata, commit, psrc, ra | req, addr, valid, inst, pc4, err
      vq.push_back(mk(1'b1, 32'hDEAD_BEEF, 1'b1, 2'b00, 32'h0, 1'b1, 32'h0000_0000, 1'b0, 32'h0, 32'h0000_0004, 1'b0));
      vq.push_back(mk(1'b1, 32'h2001_0001, 1'b1, 2'b00, 32'h0, 1'b0, 32'h0000_0000, 1'b1, 32'h2001_0001, 32'h0000_0004, 1'b0));
      vq.push_back(mk(1'b1, 32'hBAD0_BAD0, 1'b1, 2'b00, 32'h0, 1'b1, 32'h0000_0004, 1'b0, 32'h0, 32'h0000_0008, 1'b0));
      vq.push_back(mk(1'b1, 32'h8C22_0004, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0000_0004, 1'b1, 32'h8C22_0004, 32'h0000_0008, 1'b0));
      vq.push_back(mk(1'b0, 32'h0, 1'b1, 2'b00, 32'h0, 1'b1, 32'h0000_0008, 1'b0, 32'h0, 32'h0000_000C, 1'b0));
      vq.push_back(mk(1'b1, 32'h0149_5020, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0000_0008, 1'b1, 32'h0149_5020, 32'h0000_000C, 1'b0));
      vq.push_back(mk(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0000_0008, 1'b1, 32'h0149_5020, 32'h0000_000C, 1'b0));
      vq.push_back(mk(1'b1, 32'hBAD1_BAD1, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0000_0008, 1'b1, 32'h0149_5020, 32'h0000_000C, 1'b0));
      vq.push_back(mk(1'b0, 32'h0, 1'b1, 2'b00, 32'h0, 1'b1, 32'h0000_000C, 1'b0, 32'h0, 32'h0000_0010, 1'b0));
      vq.push_back(mk(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 1'b1, 32'h0000_000C, 1'b0, 32'h0, 32'h0000_0010, 1'b0));
      vq.push_back(mk(1'b1, 32'h03E0_0008, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0000_000C, 1'b1, 32'h03E0_0008, 32'h0000_0010, 1'b0));
      vq.push_back(mk(1'b0, 32'h0, 1'b1, 2'b10, 32'h0000_0100, 1'b1, 32'h0000_0100, 1'b0, 32'h0, 32'h0000_0104, 1'b0));
      vq.push_back(mk(1'b1, 32'h1000_FFFE, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0000_0100, 1'b1, 32'h1000_FFFE, 32'h0000_0104, 1'b0));
      vq.push_back(mk(1'b0, 32'h0, 1'b1, 2'b01, 32'h0, 1'b1, 32'h0000_00FC, 1'b0, 32'h0, 32'h0000_0100, 1'b0));
      vq.push_back(mk(1'b1, 32'h03E0_0008, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0000_00FC, 1'b1, 32'h03E0_0008, 32'h0000_0100, 1'b0));
      vq.push_back(mk(1'b0, 32'h0, 1'b1, 2'b10, 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b0, 32'h0, 32'h8000_0004, 1'b0));
      vq.push_back(mk(1'b1, 32'h0C00_0040, 1'b0, 2'b00, 32'h0, 1'b0, 32'h8000_0000, 1'b1, 32'h0C00_0040, 32'h8000_0004, 1'b0));
      vq.push_back(mk(1'b0, 32'h0, 1'b1, 2'b11, 32'h0, 1'b1, 32'h8000_0100, 1'b0, 32'h0, 32'h8000_0104, 1'b0));
      vq.push_back(mk(1'b1, 32'h03E0_0008, 1'b0, 2'b00, 32'h0, 1'b0, 32'h8000_0100, 1'b1, 32'h03E0_0008, 32'h8000_0104, 1'b0));
      vq.push_back(mk(1'b0, 32'h0, 1'b1, 2'b10, 32'h0000_2000, 1'b1, 32'h0000_2000, 1'b0, 32'h0, 32'h0000_2004, 1'b0));
      vq.push_back(mk(1'b1, 32'h0000_0009, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0000_2000, 1'b1, 32'h0000_0009, 32'h0000_2004, 1'b0));
      vq.push_back(mk(1'b0, 32'h0, 1'b1, 2'b01, 32'h0, 1'b1, 32'h0000_2028, 1'b0, 32'h0, 32'h0000_202C, 1'b0));
      vq.push_back(mk(1'b1, 32'h03E0_0008, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0000_2028, 1'b1, 32'h03E0_0008, 32'h0000_202C, 1'b0));
      vq.push_back(mk(1'b0, 32'h0, 1'b1, 2'b10, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0000_0000, 1'b0));
      vq.push_back(mk(1'b1, 32'h1234_5678, 1'b0, 2'b00, 32'h0, 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h1234_5678, 32'h0000_0000, 1'b0));
      vq.push_back(mk(1'b0, 32'h0, 1'b1, 2'b00, 32'h0, 1'b1, 32'h0000_0000, 1'b0, 32'h0, 32'h0000_0004, 1'b0));
      vq.push_back(mk(1'b1, 32'hA5A5_0000, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0000_0000, 1'b1, 32'hA5A5_0000, 32'h0000_0004, 1'b0));
      vq.push_back(mk(1'b0, 32'h0, 1'b1, 2'b10, 32'h0000_2002, 1'b0, 32'h0000_0000, 1'b0, 32'h0, 32'h0000_0004, 1'b1));
      vq.push_back(mk(1'b1, 32'h0, 1'b1, 2'b00, 32'h0, 1'b0, 32'h0000_0000, 1'b0, 32'h0, 32'h0000_0004, 1'b1));
      vq.push_back(mk(1'b1, 32'h0, 1'b1, 2'b11, 32'h0, 1'b0, 32'h0000_0000, 1'b0, 32'h0, 32'h0000_0004, 1'b1));

      // ---------------- table-driven fetch sequence ----------------
      do_reset("tbl");
      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].ack, vq[i].rdata, vq[i].cmt, vq[i].psrc, vq[i].rav);
         step();
         chk($sformatf("v%0d req", i),   bus.imem_req, vq[i].e_req);
         chk($sformatf("v%0d addr", i),  bus.imem_addr, vq[i].e_addr);
         chk($sformatf("v%0d pc", i),    pc, vq[i].e_addr);
         chk($sformatf("v%0d valid", i), inst_valid, vq[i].e_valid);
         chk($sformatf("v%0d pc4", i),   pc4, vq[i].e_pc4);
         chk($sformatf("v%0d err", i),   fetch_err, vq[i].e_err);
         if (vq[i].e_valid) begin
            chk($sformatf("v%0d inst", i), inst, vq[i].e_inst);
         end
      end

      // ---------------- timeout: 16 cycles without ack ----------------
      do_reset("to16");
      step();
      chk("to16 req up", bus.imem_req, 32'd1);
      for (int k = 1; k <= 16; k++) begin
         step();
         if (k == 15) begin
            chk("to16 err@15", fetch_err, 32'd0);
            chk("to16 req@15", bus.imem_req, 32'd1);
         end
      end
      chk("to16 err@16", fetch_err, 32'd1);
      chk("to16 req@16", bus.imem_req, 32'd0);
      chk("to16 valid", inst_valid, 32'd0);
      drive(1'b1, 32'h1111_1111, 1'b1, 2'b00, 32'h0);
      step();
      step();
      chk("to16 sticky err", fetch_err, 32'd1);
      chk("to16 sticky req", bus.imem_req, 32'd0);
      chk("to16 sticky valid", inst_valid, 32'd0);

      // ---------------- ack on 15th wait cycle: no fault ----------------
      do_reset("to15");
      step();
      for (int k = 1; k <= 14; k++) begin
         step();
      end
      drive(1'b1, 32'h2222_3333, 1'b0, 2'b00, 32'h0);
      step();
      chk("to15 valid", inst_valid, 32'd1);
      chk("to15 inst", inst, 32'h2222_3333);
      chk("to15 err", fetch_err, 32'd0);
      // Commit, then wait 15 more cycles: the counter must have restarted from zero.
      drive(1'b0, 32'h0, 1'b1, 2'b00, 32'h0);
      step();
      chk("to15 addr4", bus.imem_addr, 32'h0000_0004);
      drive(1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
      for (int k = 1; k <= 15; k++) begin
         step();
      end
      chk("to15 cnt clr err", fetch_err, 32'd0);
      chk("to15 cnt clr req", bus.imem_req, 32'd1);
      drive(1'b1, 32'h4444_5555, 1'b0, 2'b00, 32'h0);
      step();
      chk("to15 2nd inst", inst, 32'h4444_5555);
      chk("to15 2nd valid", inst_valid, 32'd1);

      // ---------------- reset in the middle of a pending request ----------------
      do_reset("mid");
      step();
      drive(1'b1, 32'h6666_7777, 1'b0, 2'b00, 32'h0);
      step();
      drive(1'b0, 32'h0, 1'b1, 2'b00, 32'h0);
      step();
      drive(1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
      step();
      step();
      step();
      chk("mid req before", bus.imem_req, 32'd1);
      chk("mid addr before", bus.imem_addr, 32'h0000_0004);
      reset = 1'b1;
      #1;
      chk("mid req async", bus.imem_req, 32'd0);
      chk("mid pc async", pc, 32'h0000_0000);
      chk("mid err async", fetch_err, 32'd0);
      chk("mid valid async", inst_valid, 32'd0);
      step();
      reset = 1'b0;
      step();
      chk("mid resume req", bus.imem_req, 32'd1);
      chk("mid resume addr", bus.imem_addr, 32'h0000_0000);
      drive(1'b1, 32'h8888_9999, 1'b0, 2'b00, 32'h0);
      step();
      chk("mid resume valid", inst_valid, 32'd1);
      chk("mid resume inst", inst, 32'h8888_9999);
      chk("mid resume pc", pc, 32'h0000_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
